alu_serial_seq: RTL and testbench

//  Bit-serial sequencer directly upstream and downstream of the 1-bit ALU slice.

---
 rtl/alu_serial_pkg.sv | 41 ++++
 rtl/alu_serial_shreg.sv | 27 ++
 rtl/alu_serial_seq.sv | 158 +++++++++++++++
 tb/tb_alu_serial_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU sequencer:
// slice opcodes, FSM state encodings, flag indices, opcode helpers.
package alu_serial_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_NAND  = 4'b0110;
    localparam logic [3:0] OP_XNOR  = 4'b0111;
    localparam logic [3:0] OP_PASSA = 4'b1000;
    localparam logic [3:0] OP_PASSB = 4'b1001;
    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] OP_CMPB  = 4'b1100;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // B-inverting ops need carry-in 1 on bit 0 (two's complement).
    function automatic logic inverts_b(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_CMP) || (op == OP_CMPB);
    endfunction

    function automatic logic is_cmp(input logic [3:0] op);
        return (op == OP_CMP) || (op == OP_CMPB);
    endfunction

    function automatic logic has_ovf(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_shreg.sv
// WIDTH-bit shift register: parallel load, shift right, serial in at MSB.
// Ports: clk, rst_n, load/load_data, shift/serial_in, data (current word).
module alu_serial_shreg
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= {serial_in, data[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer around an external 1-bit ALU slice, LSB first.
// Ports: in_* request handshake, slice_* slice link, out_* result handshake.
// Option ALU_SERIAL_FLAGS_EN adds the registered out_flags {N,Z,C,V} port.
module alu_serial_seq
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [3:0]       slice_opcode,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    input  logic             slice_result,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    output logic [3:0]       out_flags
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic [3:0]     op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;

    logic idle;
    logic run;
    logic done;
    logic accept;
    logic last;

    assign idle   = (state == ST_IDLE);
    assign run    = (state == ST_RUN);
    assign done   = (state == ST_DONE);
    assign in_ready = idle | (done & out_ready);
    assign accept = in_valid & in_ready;
    assign last   = run && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            unique case (1'b1)
                idle: if (accept) state <= ST_RUN;
                run:  if (last) state <= ST_DONE;
                done: begin
                    if (out_ready)
                        state <= in_valid ? ST_RUN : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            carry <= 1'b0;
            op_q  <= '0;
        end else if (accept) begin
            cnt   <= '0;
            carry <= inverts_b(in_opcode);
            op_q  <= in_opcode;
        end else if (run) begin
            cnt   <= cnt + 1'b1;
            carry <= slice_cout;
        end
    end

    alu_serial_shreg #(.WIDTH(WIDTH)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (in_a),
        .shift     (run),
        .serial_in (1'b0),
        .data      (a_q)
    );

    alu_serial_shreg #(.WIDTH(WIDTH)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (in_b),
        .shift     (run),
        .serial_in (1'b0),
        .data      (b_q)
    );

    // Result bits enter at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    alu_serial_shreg #(.WIDTH(WIDTH)) u_res (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data ('0),
        .shift     (run),
        .serial_in (slice_result),
        .data      (res_q)
    );

    // Only bit 0 of the operand registers feeds the slice.
    logic unused_bits;
    assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};

    assign slice_opcode = run ? op_q : 4'b0000;
    assign slice_a      = run & a_q[0];
    assign slice_b      = run & b_q[0];
    assign slice_cin    = run & carry;

    assign out_valid  = done;
    assign out_result = res_q;

`ifdef ALU_SERIAL_FLAGS_EN
    logic       zacc;
    logic       zbit;
    logic [3:0] flags_q;

    // Compares report equality of operands, everything else a zero result.
    assign zbit = is_cmp(op_q) ? (slice_a == slice_b) : ~slice_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zacc    <= 1'b0;
            flags_q <= '0;
        end else begin
            if (accept) begin
                zacc <= 1'b1;
            end else if (run) begin
                zacc <= zacc & zbit;
            end
            if (last) begin
                flags_q[FLAG_N] <= slice_result;
                flags_q[FLAG_Z] <= zacc & zbit;
                flags_q[FLAG_C] <= slice_cout;
                flags_q[FLAG_V] <= has_ovf(op_q) & (slice_cin ^ slice_cout);
            end
        end
    end

    assign out_flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural 1-bit slice.
// Covers ADD/SUB/CMP, DONE stall, back-to-back accept, mid-run reset.
module tb_alu_serial_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       slice_opcode;
    logic             slice_a;
    logic             slice_b;
    logic             slice_cin;
    logic             slice_result;
    logic             slice_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
`ifdef ALU_SERIAL_FLAGS_EN
    logic [3:0]       out_flags;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_a         (in_a),
        .in_b         (in_b),
        .slice_opcode (slice_opcode),
        .slice_a      (slice_a),
        .slice_b      (slice_b),
        .slice_cin    (slice_cin),
        .slice_result (slice_result),
        .slice_cout   (slice_cout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result)
`ifdef ALU_SERIAL_FLAGS_EN
        ,
        .out_flags    (out_flags)
`endif
    );

    // Behavioural slice: ADD, SUB, compares (carry only), others yield 0.
    logic [1:0] s_add;
    logic [1:0] s_sub;
    always_comb begin
        s_add = {1'b0, slice_a} + {1'b0, slice_b} + {1'b0, slice_cin};
        s_sub = {1'b0, slice_a} + {1'b0, ~slice_b} + {1'b0, slice_cin};
        slice_result = 1'b0;
        slice_cout   = 1'b0;
        case (slice_opcode)
            4'b0000: {slice_cout, slice_result} = s_add;
            4'b0001: {slice_cout, slice_result} = s_sub;
            4'b1011,
            4'b1100: slice_cout = s_sub[1];
            default: ;
        endcase
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE and wait (bounded) for out_valid.
    task automatic start_op(input string tag, input logic [3:0] op,
                            input logic [7:0] a, input logic [7:0] b);
        int n;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_lat"}, n, WIDTH);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_ov_low"}, out_valid, 0);
        check({tag, "_ir_high"}, in_ready, 1);
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp);
`ifdef ALU_SERIAL_FLAGS_EN
        check({tag, "_flags"}, out_flags, exp);
`else
        if (exp === 4'bxxxx) check({tag, "_flags"}, 0, 1);
`endif
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_slice", {slice_opcode, slice_a, slice_b, slice_cin}, 0);
`ifdef ALU_SERIAL_FLAGS_EN
        check("rst_flags", out_flags, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: ADD
        start_op("add", 4'b0000, 8'h5A, 8'h33);
        check("add_res", out_result, 8'h8D);
        check_flags("add", 4'b1001);
        finish_op("add");

        // 2: SUB
        start_op("sub0", 4'b0001, 8'h10, 8'h10);
        check("sub0_res", out_result, 8'h00);
        check_flags("sub0", 4'b0110);
        finish_op("sub0");
        start_op("subm", 4'b0001, 8'h00, 8'h01);
        check("subm_res", out_result, 8'hFF);
        check_flags("subm", 4'b1000);
        finish_op("subm");

        // 3: CMP
        start_op("cmpeq", 4'b1011, 8'h42, 8'h42);
        check("cmpeq_res", out_result, 8'h00);
        check_flags("cmpeq", 4'b0110);
        finish_op("cmpeq");
        start_op("cmplt", 4'b1011, 8'h41, 8'h42);
        check("cmplt_res", out_result, 8'h00);
        check_flags("cmplt", 4'b0000);
        finish_op("cmplt");

        // 4: stall in DONE, then back-to-back accept
        start_op("stall", 4'b0000, 8'h01, 8'h02);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_ov", out_valid, 1);
            check("stall_res", out_result, 8'h03);
            check("stall_ir", in_ready, 0);
        end
        in_opcode = 4'b0000;
        in_a      = 8'h7F;
        in_b      = 8'h01;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check("b2b_ir", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_ov_low", out_valid, 0);
        check("b2b_slice_a", slice_a, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check("b2b_lat", n, WIDTH);
        check("b2b_res", out_result, 8'h80);
        check_flags("b2b", 4'b1001);
        finish_op("b2b");

        // 5: reset at RUN cycle 3
        in_opcode = 4'b0000;
        in_a      = 8'hFF;
        in_b      = 8'h01;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("mid_cin", slice_cin, 1);
        rst_n = 1'b0;
        #1;
        check("mid_ir", in_ready, 1);
        check("mid_ov", out_valid, 0);
        check("mid_res", out_result, 0);
        check("mid_slice", {slice_opcode, slice_a, slice_b, slice_cin}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_op("post", 4'b0000, 8'h01, 8'h01);
        check("post_res", out_result, 8'h02);
        check_flags("post", 4'b0000);
        finish_op("post");

        // 6: unknown opcode
        start_op("unk", 4'b1111, 8'hFF, 8'hFF);
        check("unk_res", out_result, 8'h00);
        check_flags("unk", 4'b0100);
        finish_op("unk");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
